// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: blank pattern,
// segment bit positions, the hex-to-segment table and the scan state encoding.
package seg7_pkg;

  // All segments dark (outputs are active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Bit positions inside seg = {dp,g,f,e,d,c,b,a}.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-low {g,f,e,d,c,b,a} pattern for each hex digit, entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Scan FSM: BLANK keeps every anode off, SHOW drives one digit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment decoder with decimal point.
// Output order is {dp,g,f,e,d,c,b,a}; dp=1 lights the point.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Table lookup for the digit segments, inverted point for the dp segment.
  always_comb begin
    seg         = SEG_OFF;
    seg[6:0]    = HEX_SEG_TBL[nibble];
    seg[SEG_DP] = ~dp;
  end

endmodule

// File: rtl/seg7_scan_drv.sv
// Dynamic-scan driver for an N_DIG-digit common-anode 7-segment display.
// Each scan_tick advances to the next digit and opens a BLANK_CYC-cycle gap
// with all anodes off; the digit is then driven until the next tick.
// The displayed value (active) is reloaded from the shadow register only on
// the tick that wraps the digit index to 0, so a frame never tears.
// Optional feature macro: SEG7_LZB_EN enables leading-zero blanking.
//
// Input protocol: scan_tick and data_we are single-cycle strobes sampled on
// the rising clk edge; there is no back-pressure. A data_we in the same cycle
// as the wrapping tick is bypassed straight into the displayed value.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int N_DIG     = 8,
  parameter int BLANK_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_tick,
  input  logic [4*N_DIG-1:0] data_in,
  input  logic               data_we,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   dig_en,
  output logic [N_DIG-1:0]   an,
  output logic [7:0]         seg,
  output logic               frame_sync
);

  localparam int IDX_W = $clog2(N_DIG);
  localparam int CNT_W = $clog2(BLANK_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_DIG - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYC - 1);

  scan_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_DIG-1:0]     an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic                 frame_sync_q, frame_sync_d;
  logic [4*N_DIG-1:0]   shadow_q, shadow_d;
  logic [4*N_DIG-1:0]   active_q, active_d;

  logic [3:0]           cur_nibble;
  logic [7:0]           dec_seg;
  logic [N_DIG-1:0]     lzb_ok;
  logic                 show_k;
  logic                 wrap;

  assign cur_nibble = active_q[{idx_q, 2'b00} +: 4];

  seg7_hex_dec u_hex_dec (
    .nibble (cur_nibble),
    .dp     (dp_in[idx_q]),
    .seg    (dec_seg)
  );

  // Per-digit eligibility after leading-zero blanking; derived from active so it is frame-stable.
  always_comb begin
    lzb_ok = '1;
`ifdef SEG7_LZB_EN
    begin
      logic nz_above;
      nz_above = 1'b0;
      for (int k = N_DIG - 1; k > 0; k--) begin
        nz_above  = nz_above | (active_q[4*k +: 4] != 4'h0);
        lzb_ok[k] = nz_above;
      end
    end
`endif
  end

  assign show_k = dig_en[idx_q] & lzb_ok[idx_q];
  assign wrap   = (idx_q == IDX_MAX);

  // Next-state logic for the scan FSM, digit index, gap counter, value registers and outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    an_d         = an_q;
    seg_d        = seg_q;
    frame_sync_d = 1'b0;
    shadow_d     = data_we ? data_in : shadow_q;
    active_d     = active_q;

    if (scan_tick) begin
      // A tick always restarts the gap, even if the previous gap is still running.
      idx_d   = wrap ? '0 : idx_q + 1'b1;
      state_d = ST_BLANK;
      cnt_d   = CNT_LOAD;
      an_d    = '1;
      seg_d   = SEG_OFF;
      if (wrap) begin
        active_d     = data_we ? data_in : shadow_q;
        frame_sync_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d     = ST_SHOW;
            an_d        = '1;
            an_d[idx_q] = ~show_k;
            seg_d       = show_k ? dec_seg : SEG_OFF;
          end
        end
        ST_SHOW: begin
          // Outputs hold until the next tick.
        end
        default: begin
          state_d = ST_BLANK;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= IDX_MAX;
      cnt_q        <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      frame_sync_q <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_sync_q <= frame_sync_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed testbench for seg7_scan_drv (N_DIG=8, BLANK_CYC=4).
// Build with +define+SEG7_LZB_EN to check the leading-zero blanking variant.
module tb_seg7_scan_drv;

  localparam int N_DIG     = 8;
  localparam int BLANK_CYC = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        scan_tick = 1'b0;
  logic        data_we   = 1'b0;
  logic [31:0] data_in   = '0;
  logic [7:0]  dp_in     = '0;
  logic [7:0]  dig_en    = 8'hFF;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_sync;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected seg per digit for the value 32'h1234_5678, dp off.
  logic [7:0] exp_1234 [8];
  logic [7:0] one_hot;

  always #5 clk = ~clk;

  seg7_scan_drv #(
    .N_DIG     (N_DIG),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_tick  (scan_tick),
    .data_in    (data_in),
    .data_we    (data_we),
    .dp_in      (dp_in),
    .dig_en     (dig_en),
    .an         (an),
    .seg        (seg),
    .frame_sync (frame_sync)
  );

  // ---------------- driver tasks ----------------
  // Advance n rising edges; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
  endtask

  // Tick, then wait out the blanking gap so the new digit is being driven.
  task automatic tick_show();
    pulse_tick();
    step(BLANK_CYC);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h expected %h", an, 8'hFF); end
    n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h expected %h", seg, 8'hFF); end
    n_checks++; if (frame_sync !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", frame_sync); end
    step(2);
    rst_n = 1'b1;
    // Out of reset: BLANK with cnt=0 and idx=7, so digit 7 (value 0) comes up on the next edge.
    step(1);
`ifdef SEG7_LZB_EN
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL post_reset_an: got %h expected %h", an, 8'hFF); end
    n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL post_reset_seg: got %h expected %h", seg, 8'hFF); end
`else
    n_checks++; if (an !== 8'h7F) begin n_fail++; $display("FAIL post_reset_an: got %h expected %h", an, 8'h7F); end
    n_checks++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL post_reset_seg: got %h expected %h", seg, 8'hC0); end
`endif
  endtask

  task automatic test_basic();
    dig_en  = 8'hFF;
    dp_in   = 8'h00;
    data_in = 32'h1234_5678;
    data_we = 1'b1;
    step(1);
    data_we = 1'b0;
    step(2);
    // First tick after reset wraps idx to 0.
    pulse_tick();
    n_checks++; if (frame_sync !== 1'b1) begin n_fail++; $display("FAIL basic_fs_pulse: got %b expected 1", frame_sync); end
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL basic_an_t1: got %h expected %h", an, 8'hFF); end
    n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL basic_seg_t1: got %h expected %h", seg, 8'hFF); end
    step(1);
    n_checks++; if (frame_sync !== 1'b0) begin n_fail++; $display("FAIL basic_fs_single: got %b expected 0", frame_sync); end
    for (int c = 2; c <= BLANK_CYC; c++) begin
      n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL basic_gap_an c=%0d: got %h expected %h", c, an, 8'hFF); end
      if (c < BLANK_CYC) step(1);
    end
    step(1);
    n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL basic_d0_an: got %h expected %h", an, 8'hFE); end
    n_checks++; if (seg !== 8'h80) begin n_fail++; $display("FAIL basic_d0_seg: got %h expected %h", seg, 8'h80); end
    step(90);
    n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL basic_hold_an: got %h expected %h", an, 8'hFE); end
    n_checks++; if (seg !== 8'h80) begin n_fail++; $display("FAIL basic_hold_seg: got %h expected %h", seg, 8'h80); end
    for (int k = 1; k < N_DIG; k++) begin
      tick_show();
      one_hot = 8'h01 << k;
      n_checks++; if (an !== ~one_hot) begin n_fail++; $display("FAIL basic_an d%0d: got %h expected %h", k, an, ~one_hot); end
      n_checks++; if (seg !== exp_1234[k]) begin n_fail++; $display("FAIL basic_seg d%0d: got %h expected %h", k, seg, exp_1234[k]); end
    end
  endtask

  task automatic test_midframe_write();
    tick_show();
    n_checks++; if (seg !== 8'h80) begin n_fail++; $display("FAIL mid_d0_seg: got %h expected %h", seg, 8'h80); end
    data_in = 32'h0000_00AB;
    data_we = 1'b1;
    step(1);
    data_we = 1'b0;
    for (int k = 1; k < N_DIG; k++) begin
      tick_show();
      one_hot = 8'h01 << k;
      n_checks++; if (an !== ~one_hot) begin n_fail++; $display("FAIL mid_old_an d%0d: got %h expected %h", k, an, ~one_hot); end
      n_checks++; if (seg !== exp_1234[k]) begin n_fail++; $display("FAIL mid_old_seg d%0d: got %h expected %h", k, seg, exp_1234[k]); end
    end
    // Wrap: the written value now becomes visible.
    pulse_tick();
    n_checks++; if (frame_sync !== 1'b1) begin n_fail++; $display("FAIL mid_wrap_fs: got %b expected 1", frame_sync); end
    step(BLANK_CYC);
    n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL new_d0_an: got %h expected %h", an, 8'hFE); end
    n_checks++; if (seg !== 8'h83) begin n_fail++; $display("FAIL new_d0_seg: got %h expected %h", seg, 8'h83); end
    tick_show();
    n_checks++; if (an !== 8'hFD) begin n_fail++; $display("FAIL new_d1_an: got %h expected %h", an, 8'hFD); end
    n_checks++; if (seg !== 8'h88) begin n_fail++; $display("FAIL new_d1_seg: got %h expected %h", seg, 8'h88); end
  endtask

  task automatic test_leading_zeros();
    for (int k = 2; k < N_DIG; k++) begin
      tick_show();
      one_hot = 8'h01 << k;
`ifdef SEG7_LZB_EN
      n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL lzb_an d%0d: got %h expected %h", k, an, 8'hFF); end
      n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL lzb_seg d%0d: got %h expected %h", k, seg, 8'hFF); end
`else
      n_checks++; if (an !== ~one_hot) begin n_fail++; $display("FAIL zero_an d%0d: got %h expected %h", k, an, ~one_hot); end
      n_checks++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL zero_seg d%0d: got %h expected %h", k, seg, 8'hC0); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    // idx is 7: first tick wraps to 0, second tick two cycles later moves to 1.
    pulse_tick();
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL b2b_an_a: got %h expected %h", an, 8'hFF); end
    n_checks++; if (frame_sync !== 1'b1) begin n_fail++; $display("FAIL b2b_fs: got %b expected 1", frame_sync); end
    step(1);
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL b2b_an_b: got %h expected %h", an, 8'hFF); end
    pulse_tick();
    n_checks++; if (frame_sync !== 1'b0) begin n_fail++; $display("FAIL b2b_fs_off: got %b expected 0", frame_sync); end
    for (int c = 1; c < BLANK_CYC; c++) begin
      n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL b2b_gap_an c=%0d: got %h expected %h", c, an, 8'hFF); end
      step(1);
    end
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL b2b_gap_an_last: got %h expected %h", an, 8'hFF); end
    step(1);
    n_checks++; if (an !== 8'hFD) begin n_fail++; $display("FAIL b2b_d1_an: got %h expected %h", an, 8'hFD); end
    n_checks++; if (seg !== 8'h88) begin n_fail++; $display("FAIL b2b_d1_seg: got %h expected %h", seg, 8'h88); end
  endtask

  task automatic test_dig_en_bypass();
    dig_en = 8'hFD;
    dp_in  = 8'h02;
    // idx is 1: walk to 7.
    for (int k = 2; k < N_DIG; k++) tick_show();
    // Write coincident with the wrapping tick is shown in this frame.
    data_in   = 32'h0000_0059;
    data_we   = 1'b1;
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
    data_we   = 1'b0;
    n_checks++; if (frame_sync !== 1'b1) begin n_fail++; $display("FAIL byp_fs: got %b expected 1", frame_sync); end
    step(BLANK_CYC);
    n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL byp_d0_an: got %h expected %h", an, 8'hFE); end
    n_checks++; if (seg !== 8'h90) begin n_fail++; $display("FAIL byp_d0_seg: got %h expected %h", seg, 8'h90); end
    tick_show();
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL den_d1_an: got %h expected %h", an, 8'hFF); end
    n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL den_d1_seg: got %h expected %h", seg, 8'hFF); end
    step(20);
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL den_d1_hold_an: got %h expected %h", an, 8'hFF); end
    tick_show();
`ifdef SEG7_LZB_EN
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL den_d2_an: got %h expected %h", an, 8'hFF); end
`else
    n_checks++; if (an !== 8'hFB) begin n_fail++; $display("FAIL den_d2_an: got %h expected %h", an, 8'hFB); end
`endif
    for (int k = 3; k < N_DIG; k++) tick_show();
    // Decimal point on digit 0: 9 with dp lit.
    dp_in = 8'h03;
    tick_show();
    n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL dp_d0_an: got %h expected %h", an, 8'hFE); end
    n_checks++; if (seg !== 8'h10) begin n_fail++; $display("FAIL dp_d0_seg: got %h expected %h", seg, 8'h10); end
  endtask

  task automatic test_async_reset();
    // Digit 0 is being driven; reset must clear outputs before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL async_rst_an: got %h expected %h", an, 8'hFF); end
    n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL async_rst_seg: got %h expected %h", seg, 8'hFF); end
    n_checks++; if (frame_sync !== 1'b0) begin n_fail++; $display("FAIL async_rst_fs: got %b expected 0", frame_sync); end
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    exp_1234[0] = 8'h80; exp_1234[1] = 8'hF8; exp_1234[2] = 8'h82; exp_1234[3] = 8'h92;
    exp_1234[4] = 8'h99; exp_1234[5] = 8'hB0; exp_1234[6] = 8'hA4; exp_1234[7] = 8'hF9;
    one_hot = 8'h00;

    test_reset();
    test_basic();
    test_midframe_write();
    test_leading_zeros();
    test_back_to_back();
    test_dig_en_bypass();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
